md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit that produces the HI/LO registers for the E stage.
//  The E-stage output mux selects HI/LO onto AO_E for MFHI/MFLO.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode and runs a fixed-latency operation.
//  Asserts busy so hazard logic stalls dependent MD instructions and MFHI/MFLO.
// PARAMETERS
//  MULT_CYCLES  5   cycles from accepted start to HI/LO update, MULT/MULTU (>=1)
//  DIV_CYCLES   10  cycles from accepted start to HI/LO update, DIV/DIVU (>=1)
// PORTS
//  clk      in   1   clock; all state updates on rising edge
//  reset    in   1   synchronous, active-high reset
//  start    in   1   qualifies md_op this cycle
//  md_op    in   3   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD
//  A        in   32  operand rs (forwarded value)
//  B        in   32  operand rt (forwarded value)
//  busy     out  1   multi-cycle operation in progress
//  HI       out  32  HI register
//  LO       out  32  LO register
// BEHAVIOUR
//  Reset (sampled at a clock edge, wins over everything):
//   - HI=0, LO=0, busy=0, state IDLE, counter 0.
//   - Reset during RUN aborts the operation; no result is written.
//  FSM IDLE -> RUN:
//   - Trigger: start=1 and md_op in {1,2,3,4} (plus 7 with macro) at edge t.
//   - Latch A, B, op; load counter with N=MULT_CYCLES or DIV_CYCLES; busy=1 from t+1.
//  RUN -> IDLE:
//   - Counter decrements each edge.
//   - At edge t+N, HI/LO take the result and busy=0 in the same cycle.
//   - So busy is high for exactly N cycles.
//  Input handling during RUN:
//   - start and operands are ignored; the latched operands are used.
//   - Later changes on A/B do not affect the result.
//  MTHI/MTLO (op 5/6, start=1, IDLE):
//   - HI<=A or LO<=A at the next edge.
//   - busy stays 0 (single-cycle).
//   - Ignored while busy.
//  op 0, or start=0: no effect.
//   - Undefined op with start=1 in IDLE: no effect.
//  Arithmetic:
//   - MULT: {HI,LO} = signed A * signed B, full 64-bit product.
//   - MULTU: {HI,LO} = unsigned 64-bit product.
//   - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//   - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//   - DIVU: unsigned quotient/remainder.
//  Divide by zero (B==0):
//   - The full DIV_CYCLES busy period is still taken.
//   - HI and LO hold their prior values at completion.
//  Simultaneous events:
//   - A start arriving on the completion edge is ignored; busy is still high that cycle.
//   - The new op is accepted on the next cycle.
//  HI/LO change only on these edges: completion, MTHI/MTLO, reset.
// CONFIGURATION
//  Macro MD_MADD_EN:
//   - Defined: md_op=7 (MADD) accepted like MULT.
//     {HI,LO} <= {HI,LO} + signed(A*B), mod 2^64.
//     Uses the HI/LO values present at completion; latency MULT_CYCLES.
//   - Undefined: md_op=7 is treated as op 0, so no busy and no state change.
// TESTING
//  1. reset=1 for 2 cycles -> HI=0, LO=0, busy=0.
//     Then MTHI A=0x1234 -> HI=0x1234 next cycle, busy never set.
//  2. MULT A=0xFFFFFFFE(-2), B=3 -> busy high exactly 5 cycles.
//     Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//     MULTU same operands -> HI=0x2, LO=0xFFFFFFFA.
//  3. DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIVU 7/2 -> LO=3, HI=1.
//  4. Preset HI=5, LO=6; DIV B=0 -> busy 10 cycles; HI=5, LO=6 unchanged.
//     MULT with start pulsed again mid-RUN and A/B changed -> result uses the original operands.
//  5. Start MULT, assert reset at cycle 3 of RUN -> busy=0, HI=LO=0, no later write.
//     Start on the completion edge -> ignored, accepted the following cycle.
//  6. With MD_MADD_EN: HI=0, LO=0xFFFFFFFF, MADD A=1, B=1 -> HI=1, LO=0 after 5 cycles.
//     Without the macro: op 7 -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers for the E stage.
// Optional MADD (md_op=7) is compiled in when MD_MADD_EN is defined.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MD_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd7;
`endif

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          busy_q, busy_d;

    logic          accept_mul;
    logic          accept_div;
    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   div_den;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   quot;
    logic [31:0]   rem;

    always_comb begin
        accept_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MD_MADD_EN
        accept_mul = accept_mul || (md_op == OP_MADD);
`endif
        accept_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
    end

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    always_comb begin
        prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        a_neg   = (op_q == OP_DIV) && a_q[31];
        b_neg   = (op_q == OP_DIV) && b_q[31];
        a_mag   = a_neg ? (32'd0 - a_q) : a_q;
        b_mag   = b_neg ? (32'd0 - b_q) : b_q;
        div_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / div_den;
        r_mag   = a_mag % div_den;
        quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Handshake: start+md_op are taken only in IDLE; while busy=1 every start is dropped,
    // so the issuer must hold a dependent op until busy is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (accept_mul || accept_div) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        op_d    = md_op;
                        a_d     = A;
                        b_d     = B;
                        cnt_d   = accept_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    end else if (md_op == OP_MTHI) begin
                        hi_d = A;
                    end else if (md_op == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem;
                                lo_d = quot;
                            end
                        end
`ifdef MD_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed operations, expected {cycles, HI, LO} queued per multi-cycle op.
// Honours MD_MADD_EN the same way the design does.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    logic [95:0] exp_q[$];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        cyc();
        start = 1'b0;
        md_op = 3'd0;
    endtask

    task automatic expect_done(input int cycles, input logic [31:0] hi, input logic [31:0] lo);
        exp_q.push_back({cycles[31:0], hi, lo});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            cyc();
        end
        total++;
        if (exp_q.size() != 0 || busy) begin
            bad++;
            $display("FAIL idle_timeout: pending=%0d busy=%b required pending=0 busy=0", exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    // Monitor: counts busy cycles and checks HI/LO on every completion (busy falling).
    logic        rst_seen = 1'b0;
    logic        prev_busy = 1'b0;
    int          busy_cnt = 0;
    logic [95:0] exp_item;

    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        if (rst_seen) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy === 1'b1) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got HI=%h LO=%h required no completion", HI, LO);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("busy_cycles", busy_cnt, exp_item[95:64]);
                    check("done_hi", HI, exp_item[63:32]);
                    check("done_lo", LO, exp_item[31:0]);
                end
                busy_cnt = 0;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        drive(3'd5, 32'h0000_1234, 32'd0);
        check("mthi_hi", HI, 32'h0000_1234);
        check("mthi_lo", LO, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);

        expect_done(5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        drive(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle();
        expect_done(5, 32'h0000_0002, 32'hFFFF_FFFA);
        drive(3'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle();

        expect_done(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drive(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        expect_done(10, 32'd1, 32'd3);
        drive(3'd4, 32'd7, 32'd2);
        wait_idle();
        expect_done(10, 32'd0, 32'h8000_0000);
        drive(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        expect_done(10, 32'd1, 32'hFFFF_FFFD);
        drive(3'd3, 32'd7, 32'hFFFF_FFFE);
        wait_idle();

        drive(3'd5, 32'd5, 32'd0);
        drive(3'd6, 32'd6, 32'd0);
        expect_done(10, 32'd5, 32'd6);
        drive(3'd3, 32'd100, 32'd0);
        wait_idle();

        expect_done(5, 32'd0, 32'd12);
        drive(3'd1, 32'd3, 32'd4);
        cyc();
        cyc();
        drive(3'd1, 32'd100, 32'd100);
        A = 32'd7;
        B = 32'd9;
        wait_idle();
        cyc();
        cyc();
        check("no_second_op_busy", {31'd0, busy}, 32'd0);

        drive(3'd5, 32'h11, 32'd0);
        drive(3'd6, 32'h22, 32'd0);
        drive(3'd1, 32'd5, 32'd5);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        for (int i = 0; i < 8; i++) cyc();
        check("abort_late_hi", HI, 32'd0);
        check("abort_late_lo", LO, 32'd0);
        check("abort_late_busy", {31'd0, busy}, 32'd0);

        expect_done(5, 32'd0, 32'd6);
        expect_done(5, 32'd0, 32'd100);
        drive(3'd1, 32'd2, 32'd3);
        for (int i = 0; i < 4; i++) cyc();
        check("pre_done_busy", {31'd0, busy}, 32'd1);
        start = 1'b1;
        md_op = 3'd2;
        A     = 32'd10;
        B     = 32'd10;
        cyc();
        check("done_edge_start_ignored", {31'd0, busy}, 32'd0);
        cyc();
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        check("next_cycle_accept", {31'd0, busy}, 32'd1);
        wait_idle();

`ifdef MD_MADD_EN
        drive(3'd5, 32'd0, 32'd0);
        drive(3'd6, 32'hFFFF_FFFF, 32'd0);
        expect_done(5, 32'd1, 32'd0);
        drive(3'd7, 32'd1, 32'd1);
        wait_idle();
`else
        drive(3'd5, 32'hAA, 32'd0);
        drive(3'd6, 32'hBB, 32'd0);
        drive(3'd7, 32'd1, 32'd1);
        check("op7_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) cyc();
        check("op7_late_busy", {31'd0, busy}, 32'd0);
        check("op7_hi", HI, 32'hAA);
        check("op7_lo", LO, 32'hBB);
`endif

        for (int i = 0; i < 3; i++) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
